// File: rtl/pc_unit.sv
// Program-counter unit: holds or advances the fetch address by SEQ/BRANCH/JUMP/CALL/RET.
// Define PC_RAS_EN to build the circular return-address stack; otherwise CALL=JUMP, RET=SEQ.
module pc_unit #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = {WIDTH{1'b0}},
   parameter int unsigned      STEP       = 4,
   parameter int unsigned      RAS_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             en,
   input  logic [2:0]                       mode,
   input  logic [WIDTH-1:0]                 imm,
   input  logic [WIDTH-1:0]                 target,
   output logic [WIDTH-1:0]                 addr,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
   output logic                             ras_ovf,
   output logic                             ras_unf
);

   localparam int unsigned      SHIFT      = $clog2(STEP);
   localparam int unsigned      CW         = $clog2(RAS_DEPTH+1);
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - {{(WIDTH-1){1'b0}}, 1'b1});

   localparam logic [2:0] MODE_SEQ    = 3'd0;
   localparam logic [2:0] MODE_BRANCH = 3'd1;
   localparam logic [2:0] MODE_JUMP   = 3'd2;
   localparam logic [2:0] MODE_CALL   = 3'd3;
   localparam logic [2:0] MODE_RET    = 3'd4;

   logic [WIDTH-1:0] addr_r;
   logic [WIDTH-1:0] addr_nxt_s;
   logic [WIDTH-1:0] seq_s;
   logic [WIDTH-1:0] branch_s;
   logic [WIDTH-1:0] jump_s;
   logic [WIDTH-1:0] ret_addr_s;
   logic             ret_ok_s;

   // imm counts instructions, so scaling by STEP is a plain shift
   assign seq_s    = addr_r + STEP_W;
   assign branch_s = seq_s + (imm << SHIFT);
   assign jump_s   = target & ALIGN_MASK;

   // next-address selection
   always_comb begin
      addr_nxt_s = addr_r;
      if (en) begin
         case (mode)
            MODE_SEQ:    addr_nxt_s = seq_s;
            MODE_BRANCH: addr_nxt_s = branch_s;
            MODE_JUMP:   addr_nxt_s = jump_s;
            MODE_CALL:   addr_nxt_s = jump_s;
            MODE_RET:    addr_nxt_s = ret_ok_s ? ret_addr_s : seq_s;
            default:     addr_nxt_s = seq_s;
         endcase
      end else begin
         addr_nxt_s = addr_r;
      end
   end

   // program-counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_r <= RESET_ADDR;
      end else begin
         addr_r <= addr_nxt_s;
      end
   end

   assign addr = addr_r;

`ifdef PC_RAS_EN
   localparam int unsigned PW = $clog2(RAS_DEPTH);

   logic [WIDTH-1:0] ras_r [RAS_DEPTH];
   logic [PW-1:0]    top_r;
   logic [PW-1:0]    top_inc_s;
   logic [PW-1:0]    top_dec_s;
   logic [CW-1:0]    count_r;
   logic             ovf_r;
   logic             unf_r;
   logic             push_s;
   logic             pop_s;
   logic             unf_s;
   logic             empty_s;
   logic             full_s;

   // stack control; pointer wraps modulo RAS_DEPTH, which need not be a power of two
   always_comb begin
      empty_s   = (count_r == {CW{1'b0}});
      full_s    = (count_r == CW'(RAS_DEPTH));
      push_s    = en && (mode == MODE_CALL);
      pop_s     = en && (mode == MODE_RET) && !empty_s;
      unf_s     = en && (mode == MODE_RET) && empty_s;
      top_inc_s = (top_r == PW'(RAS_DEPTH-1)) ? {PW{1'b0}} : top_r + PW'(1);
      top_dec_s = (top_r == {PW{1'b0}}) ? PW'(RAS_DEPTH-1) : top_r - PW'(1);
   end

   assign ret_ok_s   = pop_s;
   assign ret_addr_s = ras_r[top_r];

   // RAS storage, pointer, count and sticky flags; a full push overwrites the oldest slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            ras_r[i] <= {WIDTH{1'b0}};
         end
         top_r   <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else if (push_s) begin
         ras_r[top_inc_s] <= seq_s;
         top_r            <= top_inc_s;
         if (full_s) begin
            ovf_r <= 1'b1;
         end else begin
            count_r <= count_r + CW'(1);
         end
      end else if (pop_s) begin
         top_r   <= top_dec_s;
         count_r <= count_r - CW'(1);
      end else if (unf_s) begin
         unf_r <= 1'b1;
      end
   end

   assign ras_count = count_r;
   assign ras_ovf   = ovf_r;
   assign ras_unf   = unf_r;
`else
   assign ret_ok_s   = 1'b0;
   assign ret_addr_s = seq_s;
   assign ras_count  = {CW{1'b0}};
   assign ras_ovf    = 1'b0;
   assign ras_unf    = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, the successor to the single-mode PC block. Each enabled cycle it holds or advances the instruction address by one of five modes: sequential, relative branch, absolute jump, call and return. Call and return use an optional circular return-address stack (RAS). It sits at the front of the fetch stage and drives the instruction-memory address.

## Interface
- `WIDTH`, 32: address width in bits.
- `RESET_ADDR`, 0: value loaded into `addr` on reset.
- `STEP`, 4: byte increment per instruction; must be a power of two ≥1.
- `RAS_DEPTH`, 4: RAS entries; must be ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; 0 = hold all state, including the RAS.
- `mode`  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; 5–7 are treated as SEQ.
- `imm`  in  WIDTH  signed branch offset in instructions.
- `target`  in  WIDTH  absolute jump/call byte address.
- `addr`  out  WIDTH  current PC (registered).
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- `ras_ovf`  out  1  sticky: a CALL was made while the RAS was full.
- `ras_unf`  out  1  sticky: a RET was made while the RAS was empty.

## Operation
- Reset (`reset`=0, any time, asynchronous): `addr`=RESET_ADDR, `ras_count`=0, `ras_ovf`=0, `ras_unf`=0, all RAS entries=0.
- `en`=0: nothing changes; `mode`, `imm` and `target` are ignored.
- With `en`=1, `addr` takes the following value at the next edge. All arithmetic is modulo 2^WIDTH and wraps silently.
  - SEQ: `addr`+STEP.
  - BRANCH: `addr`+STEP+`imm`·STEP. `imm` is sign-extended and the multiply is implemented as a shift by log2(STEP).
  - JUMP: `target`, with its low log2(STEP) bits forced to 0.
  - CALL: same as JUMP; in the same cycle `addr`+STEP is pushed onto the RAS.
  - RET: the RAS top is popped and loaded into `addr`.
- RAS is a circular buffer with a top-of-stack pointer.
  - Push when not full: write at top+1, top advances, `ras_count`+1.
  - Push when full (`ras_count`=RAS_DEPTH): the oldest entry is overwritten, `ras_count` stays at RAS_DEPTH, and `ras_ovf` is set.
  - Pop when not empty: `addr` gets the top entry, top retreats, `ras_count`−1.
  - Pop when empty: treated as SEQ (`addr`+STEP), `ras_unf` is set, and the pointer and count are unchanged.
- `ras_ovf` and `ras_unf` clear only on reset.
- Only one RAS operation can happen per cycle (mode is one-hot in effect), so a simultaneous push and pop cannot occur.

## Timing
- Latency is 1 cycle: inputs sampled at edge N are reflected in `addr`, `ras_count` and the flags after edge N.
- `addr` and the flags are registered with no combinational path from any input to any output. The only exception is the asynchronous reset path.
- A reset asserted mid-cycle forces outputs immediately. After deassertion, the first update is at the next rising edge with `en`=1.
- Back-to-back CALL/RET on consecutive cycles is fully supported; a RET immediately after a CALL returns the address just pushed.

## Configuration
- `PC_RAS_EN` defined: the RAS, `ras_count`, `ras_ovf` and `ras_unf` are implemented as described above.
- `PC_RAS_EN` undefined:
  - No RAS storage is built.
  - CALL behaves exactly as JUMP.
  - RET behaves exactly as SEQ.
  - `ras_count`, `ras_ovf` and `ras_unf` are tied to 0.
  - Ports are unchanged.

## Test plan
- Reset, then SEQ with `en`=1 for 3 cycles (defaults) → `addr` 0x0, 0x4, 0x8, 0xC. Toggling `en`=0 holds `addr` at its current value.
- From `addr`=0x100, BRANCH with `imm`=−2 → 0xFC. Then BRANCH with `imm`=+3 → 0x10C. From 0xFFFFFFFC, SEQ → 0x0 (wrap).
- JUMP with `target`=0x2003 → 0x2000. CALL with `target`=0x400 from 0x2000 → `addr`=0x400, `ras_count`=1. RET → `addr`=0x2004, `ras_count`=0.
- With RAS_DEPTH=4, five CALLs from `addr` values A1..A5 → `ras_count`=4 and `ras_ovf`=1. Five RETs then return A5+4, A4+4, A3+4 and A2+4. The fifth RET gives previous `addr`+4 and sets `ras_unf`=1.
- Assert `reset` asynchronously between edges with `ras_count`=3 → `addr`=RESET_ADDR, `ras_count`=0 and both flags 0 before the next edge.
- Build without `PC_RAS_EN`: CALL to 0x400 → `addr`=0x400, `ras_count`=0. RET → 0x404, `ras_unf`=0.
